// File: rtl/tuner_phy_pkg.sv
// Shared types and helpers for the ring-tuner PHY sequencer.
package tuner_phy_pkg;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        DRIVE  = 3'd1,
        SETTLE = 3'd2,
        ACCUM  = 3'd3,
        REPORT = 3'd4
    } tuner_afe_seq_state_e;

    // Width of a field able to hold 0..max_val.
    function automatic int unsigned cfg_width(input int unsigned max_val);
        return (max_val < 1) ? 1 : $clog2(max_val + 1);
    endfunction

endpackage

// File: rtl/tuner_afe_seq_phy_if.sv
// Digital request/response and AFE DAC/ADC signals of the tuner sequencer.
interface tuner_afe_seq_phy_if
    import tuner_phy_pkg::*;
#(
    parameter int unsigned DAC_WIDTH    = 8,
    parameter int unsigned ADC_WIDTH    = 8,
    parameter int unsigned SETTLE_WIDTH = 8,
    parameter int unsigned MAX_AVG_LOG2 = 4
);
    localparam int unsigned K_WIDTH = cfg_width(MAX_AVG_LOG2);

    logic [DAC_WIDTH-1:0]    i_dig_ring_tune;
    logic                    i_dig_ring_tune_val;
    logic                    o_dig_ring_tune_rdy;
    logic [SETTLE_WIDTH-1:0] i_cfg_settle_cycles;
    logic [K_WIDTH-1:0]      i_cfg_avg_log2;
    logic [DAC_WIDTH-1:0]    o_afe_ring_tune;
    logic                    o_afe_ring_tune_val;
    logic                    i_afe_ring_tune_rdy;
    logic [ADC_WIDTH-1:0]    i_afe_ring_pwr;
    logic                    i_afe_ring_pwr_val;
    logic [ADC_WIDTH-1:0]    o_dig_ring_pwr;
    logic                    o_dig_ring_pwr_val;
    logic [DAC_WIDTH-1:0]    o_dig_ring_tune_applied;
    tuner_afe_seq_state_e    o_dig_seq_state_mon;

    modport slave (
        input  i_dig_ring_tune, i_dig_ring_tune_val, i_cfg_settle_cycles, i_cfg_avg_log2,
        input  i_afe_ring_tune_rdy, i_afe_ring_pwr, i_afe_ring_pwr_val,
        output o_dig_ring_tune_rdy, o_afe_ring_tune, o_afe_ring_tune_val,
        output o_dig_ring_pwr, o_dig_ring_pwr_val, o_dig_ring_tune_applied, o_dig_seq_state_mon
    );

    modport master (
        output i_dig_ring_tune, i_dig_ring_tune_val, i_cfg_settle_cycles, i_cfg_avg_log2,
        output i_afe_ring_tune_rdy, i_afe_ring_pwr, i_afe_ring_pwr_val,
        input  o_dig_ring_tune_rdy, o_afe_ring_tune, o_afe_ring_tune_val,
        input  o_dig_ring_pwr, o_dig_ring_pwr_val, o_dig_ring_tune_applied, o_dig_seq_state_mon
    );

endinterface

// File: rtl/tuner_pwr_accum.sv
// Sums 2^k ADC samples and presents the truncated average alongside the last sample.
module tuner_pwr_accum
    import tuner_phy_pkg::*;
#(
    parameter int unsigned ADC_WIDTH    = 8,
    parameter int unsigned MAX_AVG_LOG2 = 4
) (
    input  logic                                i_clk,
    input  logic                                i_rst_n,
    input  logic                                clear,
    input  logic                                en,
    input  logic                                sample_val,
    input  logic [ADC_WIDTH-1:0]                sample,
    input  logic [cfg_width(MAX_AVG_LOG2)-1:0]  k,
    output logic                                done_c,
    output logic [ADC_WIDTH-1:0]                avg_c
);
    localparam int unsigned ACC_WIDTH = ADC_WIDTH + MAX_AVG_LOG2;
    localparam int unsigned CNT_WIDTH = MAX_AVG_LOG2 + 1;

    logic [ACC_WIDTH-1:0] acc_q;
    logic [CNT_WIDTH-1:0] cnt_q;
    logic                 take_c;
    logic [ACC_WIDTH-1:0] sum_c;
    logic [CNT_WIDTH-1:0] target_c;

    // Average includes the sample arriving this cycle so the result can be registered on the last sample.
    always_comb begin
        take_c   = en && sample_val;
        sum_c    = acc_q + ACC_WIDTH'(sample);
        target_c = CNT_WIDTH'(CNT_WIDTH'(1) << k);
        done_c   = take_c && (cnt_q == (target_c - CNT_WIDTH'(1)));
        avg_c    = ADC_WIDTH'(sum_c >> k);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (clear) begin
            acc_q <= '0;
            cnt_q <= '0;
        end else if (take_c) begin
            acc_q <= sum_c;
            cnt_q <= cnt_q + CNT_WIDTH'(1);
        end
    end

endmodule

// File: rtl/tuner_afe_seq_phy.sv
// Ring-tune sequencer: drives a code to the DAC, blanks for settle, averages ADC power, reports it.
module tuner_afe_seq_phy
    import tuner_phy_pkg::*;
#(
    parameter int unsigned DAC_WIDTH    = 8,
    parameter int unsigned ADC_WIDTH    = 8,
    parameter int unsigned SETTLE_WIDTH = 8,
    parameter int unsigned MAX_AVG_LOG2 = 4,
    parameter int unsigned RESET_TUNE   = 0
) (
    input  logic               i_clk,
    input  logic               i_rst_n,
    tuner_afe_seq_phy_if.slave bus
);
    localparam int unsigned K_WIDTH = cfg_width(MAX_AVG_LOG2);

    tuner_afe_seq_state_e    state_q, state_d;
    logic [DAC_WIDTH-1:0]    tune_q;
    logic [SETTLE_WIDTH-1:0] settle_cfg_q;
    logic [SETTLE_WIDTH-1:0] settle_cnt_q;
    logic [K_WIDTH-1:0]      k_q;
    logic [K_WIDTH-1:0]      k_clamp_c;
    logic                    tune_rdy_q;
    logic                    afe_val_q;
    logic [ADC_WIDTH-1:0]    pwr_q;
    logic                    pwr_val_q;
    logic [DAC_WIDTH-1:0]    applied_q;
    logic                    accept_c;
    logic                    dac_hs_c;
    logic                    acc_en_c;
    logic                    acc_clear_c;
    logic                    acc_done_c;
    logic [ADC_WIDTH-1:0]    acc_avg_c;

    // Next-state and per-state strobes.
    always_comb begin
        state_d     = state_q;
        accept_c    = 1'b0;
        dac_hs_c    = 1'b0;
        acc_en_c    = 1'b0;
        acc_clear_c = 1'b0;
        k_clamp_c   = (bus.i_cfg_avg_log2 > K_WIDTH'(MAX_AVG_LOG2)) ?
                      K_WIDTH'(MAX_AVG_LOG2) : bus.i_cfg_avg_log2;
        case (state_q)
            IDLE: begin
                if (bus.i_dig_ring_tune_val) begin
                    accept_c = 1'b1;
                    state_d  = DRIVE;
                end
            end
            DRIVE: begin
                if (bus.i_afe_ring_tune_rdy) begin
                    dac_hs_c = 1'b1;
                    state_d  = (settle_cfg_q == '0) ? ACCUM : SETTLE;
                end
            end
            SETTLE: begin
                if (settle_cnt_q <= SETTLE_WIDTH'(1)) state_d = ACCUM;
            end
            ACCUM: begin
                acc_en_c = 1'b1;
                if (acc_done_c) state_d = REPORT;
            end
            REPORT: begin
                acc_clear_c = 1'b1;
                state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state_q <= IDLE;
        else          state_q <= state_d;
    end

    // Handshake flags are registered from the next state so they line up with the state they belong to.
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            tune_q       <= DAC_WIDTH'(RESET_TUNE);
            settle_cfg_q <= '0;
            settle_cnt_q <= '0;
            k_q          <= '0;
            tune_rdy_q   <= 1'b1;
            afe_val_q    <= 1'b0;
            pwr_q        <= '0;
            pwr_val_q    <= 1'b0;
            applied_q    <= DAC_WIDTH'(RESET_TUNE);
        end else begin
            tune_rdy_q <= (state_d == IDLE);
            afe_val_q  <= (state_d == DRIVE);
            pwr_val_q  <= acc_done_c;
            if (accept_c) begin
                tune_q       <= bus.i_dig_ring_tune;
                settle_cfg_q <= bus.i_cfg_settle_cycles;
                k_q          <= k_clamp_c;
            end
            if (dac_hs_c) begin
                settle_cnt_q <= settle_cfg_q;
            end else if (state_q == SETTLE && settle_cnt_q != '0) begin
                settle_cnt_q <= settle_cnt_q - SETTLE_WIDTH'(1);
            end
            if (acc_done_c) begin
                pwr_q     <= acc_avg_c;
                applied_q <= tune_q;
            end
        end
    end

    tuner_pwr_accum #(
        .ADC_WIDTH    (ADC_WIDTH),
        .MAX_AVG_LOG2 (MAX_AVG_LOG2)
    ) u_accum (
        .i_clk      (i_clk),
        .i_rst_n    (i_rst_n),
        .clear      (acc_clear_c),
        .en         (acc_en_c),
        .sample_val (bus.i_afe_ring_pwr_val),
        .sample     (bus.i_afe_ring_pwr),
        .k          (k_q),
        .done_c     (acc_done_c),
        .avg_c      (acc_avg_c)
    );

    assign bus.o_dig_ring_tune_rdy     = tune_rdy_q;
    assign bus.o_afe_ring_tune         = tune_q;
    assign bus.o_afe_ring_tune_val     = afe_val_q;
    assign bus.o_dig_ring_pwr          = pwr_q;
    assign bus.o_dig_ring_pwr_val      = pwr_val_q;
    assign bus.o_dig_ring_tune_applied = applied_q;
    assign bus.o_dig_seq_state_mon     = state_q;

endmodule

// File: tb/tb_tuner_afe_seq_phy.sv
// Directed and randomized transactions against a per-transaction sample/timing reference model.
module tb_tuner_afe_seq_phy;
    import tuner_phy_pkg::*;

    logic clk;
    logic rst_n;
    int   n_assert;
    int   n_fail;
    logic [7:0] data_q[$];

    tuner_afe_seq_phy_if bus ();

    tuner_afe_seq_phy dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction; the model counts the first 2^k valid samples at or after handshake+S+1.
    task automatic run_txn(input logic [7:0] code, input int s, input int k_cfg, input int stall,
                           input int period, input logic [7:0] blank_val, input int exp_pulse);
        int k_eff, n, h, first, got, sum, done_cyc;
        logic       v;
        logic [7:0] d;
        k_eff = (k_cfg > 4) ? 4 : k_cfg;
        n = 1 << k_eff;
        h = 1 + stall;
        first = h + s + 1;
        got = 0; sum = 0; done_cyc = -1;
        @(negedge clk);
        chk("idle_rdy", 32'(bus.o_dig_ring_tune_rdy), 32'd1);
        chk("idle_state", 32'(bus.o_dig_seq_state_mon), 32'(IDLE));
        bus.i_dig_ring_tune     = code;
        bus.i_dig_ring_tune_val = 1'b1;
        bus.i_cfg_settle_cycles = 8'(s);
        bus.i_cfg_avg_log2      = 3'(k_cfg);
        bus.i_afe_ring_tune_rdy = 1'b0;
        bus.i_afe_ring_pwr_val  = 1'b0;
        for (int c = 1; c < 4000 && done_cyc < 0; c++) begin
            @(negedge clk);
            if (c <= h) begin
                chk("drive_val", 32'(bus.o_afe_ring_tune_val), 32'd1);
                chk("drive_code", 32'(bus.o_afe_ring_tune), 32'(code));
                chk("busy_rdy", 32'(bus.o_dig_ring_tune_rdy), 32'd0);
            end
            if (got == n) begin
                chk("pwr_val", 32'(bus.o_dig_ring_pwr_val), 32'd1);
                chk("pwr", 32'(bus.o_dig_ring_pwr), 32'(sum >> k_eff));
                chk("applied", 32'(bus.o_dig_ring_tune_applied), 32'(code));
                chk("dac_hold", 32'(bus.o_afe_ring_tune), 32'(code));
                if (exp_pulse >= 0) chk("pulse_cycle", 32'(c), 32'(exp_pulse));
                done_cyc = c;
            end else if (bus.o_dig_ring_pwr_val !== 1'b0) begin
                chk("early_pulse", 32'(bus.o_dig_ring_pwr_val), 32'd0);
            end
            // Upstream keeps offering new codes and config while busy; all must be ignored.
            bus.i_dig_ring_tune_val = (done_cyc < 0);
            bus.i_dig_ring_tune     = 8'($urandom);
            bus.i_cfg_settle_cycles = 8'($urandom);
            bus.i_cfg_avg_log2      = 3'($urandom);
            bus.i_afe_ring_tune_rdy = (c >= h);
            v = ((c % period) == 0);
            if (c < first) d = blank_val;
            else if (data_q.size() > 0 && v && got < n) d = data_q.pop_front();
            else d = 8'($urandom);
            bus.i_afe_ring_pwr_val = v;
            bus.i_afe_ring_pwr     = d;
            if (v && c >= first && got < n) begin
                sum += int'(d);
                got++;
            end
        end
        if (done_cyc < 0) chk("timeout", 32'd0, 32'd1);
        bus.i_dig_ring_tune_val = 1'b0;
        bus.i_afe_ring_pwr_val  = 1'b0;
        @(negedge clk);
        chk("pulse_once", 32'(bus.o_dig_ring_pwr_val), 32'd0);
        chk("pwr_hold", 32'(bus.o_dig_ring_pwr), 32'(sum >> k_eff));
        chk("back_idle_rdy", 32'(bus.o_dig_ring_tune_rdy), 32'd1);
        data_q.delete();
    endtask

    initial begin
        n_assert = 0;
        n_fail   = 0;
        rst_n    = 1'b0;
        bus.i_dig_ring_tune     = '0;
        bus.i_dig_ring_tune_val = 1'b0;
        bus.i_cfg_settle_cycles = '0;
        bus.i_cfg_avg_log2      = '0;
        bus.i_afe_ring_tune_rdy = 1'b1;
        bus.i_afe_ring_pwr      = '0;
        bus.i_afe_ring_pwr_val  = 1'b0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_state", 32'(bus.o_dig_seq_state_mon), 32'(IDLE));
        chk("rst_tune", 32'(bus.o_afe_ring_tune), 32'd0);
        chk("rst_applied", 32'(bus.o_dig_ring_tune_applied), 32'd0);
        chk("rst_afe_val", 32'(bus.o_afe_ring_tune_val), 32'd0);
        chk("rst_pwr", 32'(bus.o_dig_ring_pwr), 32'd0);
        chk("rst_pwr_val", 32'(bus.o_dig_ring_pwr_val), 32'd0);
        chk("rst_rdy", 32'(bus.o_dig_ring_tune_rdy), 32'd1);

        // Basic: 10+20+30+41 = 101, /4 -> 25, pulse at cycle 9.
        data_q = '{8'd10, 8'd20, 8'd30, 8'd41};
        run_txn(8'h40, 3, 2, 0, 1, 8'd0, 9);

        // Settle blanking with 200s before the window.
        data_q = '{8'd8, 8'd8, 8'd8, 8'd8};
        run_txn(8'h21, 2, 2, 0, 1, 8'd200, 8);

        // DAC backpressure for 5 cycles.
        run_txn(8'h9C, 1, 1, 5, 1, 8'd0, -1);

        // Sparse ADC, k=4, all 0xFF.
        for (int i = 0; i < 16; i++) data_q.push_back(8'hFF);
        run_txn(8'h77, 4, 4, 0, 3, 8'd0, -1);

        // S=0, k=0 pass-through.
        data_q = '{8'h37};
        run_txn(8'h05, 0, 0, 0, 1, 8'd0, 3);

        // k above maximum clamps to 16 samples; then repeat the same code.
        run_txn(8'hC3, 2, 7, 1, 2, 8'hAA, -1);
        run_txn(8'hC3, 0, 1, 0, 1, 8'd0, 4);

        // Reset in the middle of ACCUM.
        @(negedge clk);
        bus.i_dig_ring_tune     = 8'h5A;
        bus.i_dig_ring_tune_val = 1'b1;
        bus.i_cfg_settle_cycles = 8'd1;
        bus.i_cfg_avg_log2      = 3'd4;
        bus.i_afe_ring_tune_rdy = 1'b1;
        bus.i_afe_ring_pwr_val  = 1'b1;
        bus.i_afe_ring_pwr      = 8'h11;
        @(negedge clk);
        bus.i_dig_ring_tune_val = 1'b0;
        repeat (4) @(negedge clk);
        chk("pre_rst_accum", 32'(bus.o_dig_seq_state_mon), 32'(ACCUM));
        rst_n = 1'b0;
        #1;
        chk("mid_rst_state", 32'(bus.o_dig_seq_state_mon), 32'(IDLE));
        chk("mid_rst_tune", 32'(bus.o_afe_ring_tune), 32'd0);
        chk("mid_rst_applied", 32'(bus.o_dig_ring_tune_applied), 32'd0);
        chk("mid_rst_afe_val", 32'(bus.o_afe_ring_tune_val), 32'd0);
        repeat (3) begin
            @(negedge clk);
            chk("mid_rst_no_pulse", 32'(bus.o_dig_ring_pwr_val), 32'd0);
        end
        bus.i_afe_ring_pwr_val = 1'b0;
        rst_n = 1'b1;
        repeat (2) begin
            @(negedge clk);
            chk("post_rst_no_pulse", 32'(bus.o_dig_ring_pwr_val), 32'd0);
        end
        data_q = '{8'd3, 8'd4};
        run_txn(8'h12, 2, 1, 0, 1, 8'd0, 6);

        // Randomized transactions.
        for (int t = 0; t < 12; t++) begin
            run_txn(8'($urandom), $urandom_range(0, 6), $urandom_range(0, 7),
                    $urandom_range(0, 3), $urandom_range(1, 3), 8'($urandom), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/tuner_afe_seq_phy.md
Name: tuner_afe_seq_phy

Overview:
- Sequencer between the control-arbitration stage and the ring AFE (DAC and ADC).
- Takes one ring-tune code per val/rdy handshake and drives it to the DAC with its own AFE handshake.
- Blanks ADC samples for a configurable settle time, then averages 2^k ADC samples.
- Returns one averaged power word per accepted code; this is the power the detect/arbitration path consumes.

Parameters:
- DAC_WIDTH, 8, ring-tune code width.
- ADC_WIDTH, 8, ADC power sample width.
- SETTLE_WIDTH, 8, width of the settle counter and its config input.
- MAX_AVG_LOG2, 4, maximum log2 of the averaging sample count.
- RESET_TUNE, 0, DAC code driven out of reset.

Ports:
- i_clk  in  1  clock.
- i_rst_n  in  1  asynchronous active-low reset.
- i_dig_ring_tune  in  DAC_WIDTH  requested tune code.
- i_dig_ring_tune_val  in  1  request valid.
- o_dig_ring_tune_rdy  out  1  request ready.
- i_cfg_settle_cycles  in  SETTLE_WIDTH  blanking cycles after DAC accept.
- i_cfg_avg_log2  in  $clog2(MAX_AVG_LOG2+1)  log2 of samples to average.
- o_afe_ring_tune  out  DAC_WIDTH  DAC code.
- o_afe_ring_tune_val  out  1  DAC code valid.
- i_afe_ring_tune_rdy  in  1  DAC ready.
- i_afe_ring_pwr  in  ADC_WIDTH  ADC sample.
- i_afe_ring_pwr_val  in  1  ADC sample valid.
- o_dig_ring_pwr  out  ADC_WIDTH  averaged power.
- o_dig_ring_pwr_val  out  1  one-cycle pulse, averaged power valid.
- o_dig_ring_tune_applied  out  DAC_WIDTH  code that o_dig_ring_pwr belongs to.
- o_dig_seq_state_mon  out  enum  FSM state monitor.

Behaviour:
- Reset (async assert, sync deassert externally):
  - State IDLE.
  - o_afe_ring_tune = RESET_TUNE; o_dig_ring_tune_applied = RESET_TUNE.
  - o_afe_ring_tune_val = 0, o_dig_ring_pwr = 0, o_dig_ring_pwr_val = 0.
  - Accumulator and all counters = 0.
  - Reset mid-operation aborts the sequence immediately; no partial result is emitted.
- FSM states: IDLE, DRIVE, SETTLE, ACCUM, REPORT.
- IDLE:
  - o_dig_ring_tune_rdy = 1; it is low in every other state.
  - On val&rdy, latch the code into o_afe_ring_tune and go to DRIVE.
  - Also latch i_cfg_settle_cycles and min(i_cfg_avg_log2, MAX_AVG_LOG2). Config changes mid-sequence have no effect.
- DRIVE:
  - o_afe_ring_tune_val = 1; the code is held stable until i_afe_ring_tune_rdy.
  - On handshake, go to SETTLE with the counter loaded to settle_cycles. If settle_cycles == 0, go directly to ACCUM.
- SETTLE:
  - Occupies exactly settle_cycles cycles; i_afe_ring_pwr_val samples are discarded.
- ACCUM:
  - Each cycle with i_afe_ring_pwr_val = 1 adds i_afe_ring_pwr to the accumulator and increments the sample count.
  - Accumulator width is ADC_WIDTH+MAX_AVG_LOG2, so it never overflows.
  - Cycles without a valid sample are held indefinitely; there is no timeout.
  - After the 2^k-th sample, go to REPORT.
- REPORT:
  - o_dig_ring_pwr = accumulator >> k, truncating, registered in this cycle.
  - o_dig_ring_pwr_val = 1 for exactly one cycle.
  - o_dig_ring_tune_applied = latched code.
  - Clear the accumulator and count, then go to IDLE.
- Between reports, o_dig_ring_pwr and o_dig_ring_tune_applied hold their values.
- Latency, with DAC rdy tied high and continuous ADC valid, accept at cycle 0:
  - DRIVE at cycle 1.
  - SETTLE at cycles 2..S+1.
  - ACCUM at cycles S+2..S+N+1.
  - REPORT pulse at cycle S+N+2.
  - Next accept earliest at cycle S+N+3.
- k = 0 averages a single sample and passes it through unchanged.
- A request identical to the last applied code still runs the full sequence.
- o_afe_ring_tune keeps the last driven code in every state; the DAC is never returned to RESET_TUNE except by reset.

Decomposition:
- tuner_phy_pkg: add enum tuner_afe_seq_state_e {IDLE, DRIVE, SETTLE, ACCUM, REPORT}.
- Sub-module tuner_pwr_accum contains:
  - the accumulator, sample counter and shift-average datapath;
  - ports: clear, sample valid/data, k, done, avg out.
- tuner_afe_seq_phy holds the FSM, the handshakes and the settle counter.

Test Plan:
- Reset: hold i_rst_n low mid-ACCUM -> state IDLE, o_afe_ring_tune = RESET_TUNE, no o_dig_ring_pwr_val; after release, first request proceeds normally.
- Basic: code 0x40, S = 3, k = 2, DAC rdy = 1, samples 10, 20, 30, 41 -> o_afe_ring_tune = 0x40 at cycle 1; pwr_val pulse at cycle 9; o_dig_ring_pwr = 25; applied = 0x40.
- Settle blanking: S = 2, ADC valid continuous with values 200, 200 then 8 × 4 (k = 2) -> result 8, not influenced by the 200s.
- Backpressure: DAC rdy low for 5 cycles in DRIVE -> o_afe_ring_tune_val held high with stable code; upstream rdy low throughout; sequence resumes on rdy.
- Sparse ADC: k = 4, valid every 3rd cycle, all samples 0xFF -> result 0xFF after exactly 16 valid samples; no overflow.
- Edge config: S = 0, k = 0, sample 0x37 -> DRIVE goes straight to ACCUM; result 0x37; config changed mid-sequence has no effect.
